axi_lite_ram: RTL and testbench

- AXI4-Lite responder (slave) backed by a word-organised synchronous RAM.
- Serves the core's imem/dmem AXI4-Lite initiator ports, e.g. as instruction ROM/RAM or data RAM in the SoC top level and in core testbenches.
- Independent read and write channel state machines, byte-strobe writes, SLVERR on out-of-range accesses.

---
 rtl/axi_lite_ram.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_lite_ram.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder backed by a word-organised synchronous RAM.
// The write and read channels run independent two-state machines. The write
// side accepts AW and W in either order, commits with byte strobes once both
// halves are present, and answers out-of-range accesses with SLVERR.
module axi_lite_ram #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   // write address channel
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   // write data channel
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   // write response channel
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   // read address channel
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   // read data channel
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH * 4);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

   // NOTE: the RAM array has no reset; contents survive rst and would otherwise
   // force the array out of block RAM into thousands of flops.
   logic [31:0] mem_q [DEPTH];

   // ---------------------------------------------------------------- write side
   w_state_e    w_state_q, w_state_d;
   logic        aw_held_q, aw_held_d;
   logic [31:0] awaddr_q,  awaddr_d;
   logic        w_held_q,  w_held_d;
   logic [31:0] wdata_q,   wdata_d;
   logic [3:0]  wstrb_q,   wstrb_d;
   logic        awready_q, awready_d;
   logic        wready_q,  wready_d;
   logic        bvalid_q,  bvalid_d;
   logic [1:0]  bresp_q,   bresp_d;

   logic          aw_hs, w_hs, commit;
   logic [31:0]   wr_addr, wr_data, wr_off;
   logic [3:0]    wr_strb;
   logic          wr_in_range, mem_we;
   logic [AW-1:0] wr_idx;

   assign aw_hs = s_axi_awvalid & awready_q;
   assign w_hs  = s_axi_wvalid  & wready_q;

   // A held half takes precedence; otherwise the half arriving this cycle is used.
   assign wr_addr     = aw_held_q ? awaddr_q : s_axi_awaddr;
   assign wr_data     = w_held_q  ? wdata_q  : s_axi_wdata;
   assign wr_strb     = w_held_q  ? wstrb_q  : s_axi_wstrb;
   assign wr_off      = wr_addr - BASE_ADDR;
   assign wr_in_range = (wr_off < SPAN);
   assign wr_idx      = wr_off[AW+1:2];
   assign commit      = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);

   // Write FSM next state: collect AW/W halves, commit, then hold B until accepted.
   always_comb begin
      // NOTE: every target gets its default first so no path leaves one unassigned
      // and no latch is inferred.
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (commit) begin
               mem_we    = wr_in_range;
               bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
               bvalid_d  = 1'b1;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               w_state_d = W_RESP;
            end else begin
               if (aw_hs) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = s_axi_awaddr;
               end
               if (w_hs) begin
                  w_held_d = 1'b1;
                  wdata_d  = s_axi_wdata;
                  wstrb_d  = s_axi_wstrb;
               end
               awready_d = !aw_held_d;
               wready_d  = !w_held_d;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write FSM state and channel registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // RAM write port: only the strobed bytes of the addressed word change.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read side
   r_state_e    r_state_q, r_state_d;
   logic        arready_q, arready_d;
   logic        rvalid_q,  rvalid_d;
   logic [31:0] rdata_q,   rdata_d;
   logic [1:0]  rresp_q,   rresp_d;

   logic          ar_hs, rd_in_range;
   logic [31:0]   rd_off;
   logic [AW-1:0] rd_idx;

   assign ar_hs       = s_axi_arvalid & arready_q;
   assign rd_off      = s_axi_araddr - BASE_ADDR;
   assign rd_in_range = (rd_off < SPAN);
   assign rd_idx      = rd_off[AW+1:2];

   // Read FSM next state: sample the RAM on AR, then hold R until accepted.
   // The sample sees pre-edge contents, so a same-edge write returns old data.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               rdata_d   = rd_in_range ? mem_q[rd_idx] : 32'h0;
               rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
               rvalid_d  = 1'b1;
               arready_d = 1'b0;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM state and channel registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Protection attributes carry no meaning for this memory.
   logic unused_prot;
   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Bench for axi_lite_ram: two instances share one set of inputs, one at base 0
// (4096 words) and one at base 0x1000 (1024 words), so every transaction is
// checked against both address maps at once.
module tb_axi_lite_ram;

   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0000_1000;
   localparam int          D0 = 4096;
   localparam int          D1 = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

   logic [1:0]  awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp [2];
   logic [1:0]  rresp [2];
   logic [31:0] rdata [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_lite_ram #(.DEPTH(D0), .BASE_ADDR(B0)) u_ram0 (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready[0]),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready[0]),
      .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready[0]),
      .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready)
   );

   axi_lite_ram #(.DEPTH(D1), .BASE_ADDR(B1)) u_ram1 (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(3'b101), .s_axi_awvalid(awvalid), .s_axi_awready(awready[1]),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready[1]),
      .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(3'b010), .s_axi_arvalid(arvalid), .s_axi_arready(arready[1]),
      .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready)
   );

   // ------------------------------------------------------------ reference model
   // Sparse word store keyed by (instance, word number).
   logic [31:0] mdl [int];

   function automatic bit in_rng(int u, logic [31:0] a);
      logic [31:0] off  = a - ((u == 0) ? B0 : B1);
      logic [31:0] span = 32'((u == 0) ? D0 * 4 : D1 * 4);
      return off < span;
   endfunction

   function automatic int mkey(int u, logic [31:0] a);
      logic [31:0] off = a - ((u == 0) ? B0 : B1);
      return (u << 28) + int'(off / 4);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int u = 0; u < 2; u++) begin
         if (in_rng(u, a)) begin
            int k = mkey(u, a);
            logic [31:0] w = mdl.exists(k) ? mdl[k] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mdl[k] = w;
         end
      end
   endtask

   // ------------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // All transaction tasks start and finish just after a falling edge.
   task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 0, w_done = 0, aw_go, w_go;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
         aw_go = awvalid && awready[0];
         w_go  = wvalid && wready[0];
         @(negedge clk);
         if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
         if (w_go)  begin wvalid  = 1'b0; w_done  = 1; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_handshake", {30'b0, aw_done, w_done}, 32'h3);
      check("bvalid_at_commit", bvalid, 2'b11);
      model_write(a, d, s);
   endtask

   task automatic wr_resp(input logic [31:0] a, input int hold, output logic [1:0] r0);
      logic [1:0] b0 = bresp[0];
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check("bvalid_hold", bvalid, 2'b11);
         check("bresp_hold", bresp[0], b0);
         check("wr_ready_hold", {awready, wready}, 4'h0);
      end
      for (int u = 0; u < 2; u++)
         check($sformatf("bresp_u%0d", u), bresp[u], in_rng(u, a) ? 2'b00 : 2'b10);
      r0 = bresp[0];
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clear", bvalid, 2'b00);
      check("wr_ready_back", {awready, wready}, 4'hF);
   endtask

   task automatic rd_issue(input logic [31:0] a);
      bit done = 0, go;
      araddr = a; arvalid = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         go = arvalid && arready[0];
         @(negedge clk);
         if (go) begin arvalid = 1'b0; done = 1; end
      end
      arvalid = 1'b0;
      check("rd_handshake", {31'b0, done}, 32'h1);
      check("rvalid_latency", rvalid, 2'b11);
   endtask

   task automatic rd_resp(input logic [31:0] a, input int hold, output logic [31:0] d0, output logic [1:0] r0);
      logic [31:0] sd = rdata[0];
      logic [1:0]  sr = rresp[0];
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         check("rvalid_hold", rvalid, 2'b11);
         check("rdata_hold", rdata[0], sd);
         check("rresp_hold", rresp[0], sr);
      end
      for (int u = 0; u < 2; u++) begin
         int k = mkey(u, a);
         if (!in_rng(u, a)) begin
            check($sformatf("rresp_u%0d", u), rresp[u], 2'b10);
            check($sformatf("rdata_u%0d", u), rdata[u], 32'h0);
         end else begin
            check($sformatf("rresp_u%0d", u), rresp[u], 2'b00);
            if (mdl.exists(k)) check($sformatf("rdata_u%0d", u), rdata[u], mdl[k]);
         end
      end
      d0 = rdata[0]; r0 = rresp[0];
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_clear", rvalid, 2'b00);
      check("arready_back", arready, 2'b11);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r0);
      wr_issue(a, d, s);
      wr_resp(a, 0, r0);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d0, output logic [1:0] r0);
      rd_issue(a);
      rd_resp(a, 0, d0, r0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] k = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
         0, 1, 2: return 32'h0000 + k;
         3, 4, 5: return 32'h1000 + k;
         6:       return 32'h4000 + k;
         default: return 32'h0FFC;
      endcase
   endfunction

   // ----------------------------------------------------------------- vectors
   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [16];

   initial begin
      logic [31:0] d;
      logic [1:0]  r;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
      tbl[3]  = '{1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
      tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
      tbl[5]  = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, 2'b10, 32'h0};
      tbl[6]  = '{1'b1, 32'h0000_0014, 32'h0102_0304, 4'hF, 2'b00, 32'h0};
      tbl[7]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
      tbl[8]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 2'b00, 32'h0102_0304};
      tbl[9]  = '{1'b1, 32'h0000_0013, 32'hAABB_CCDD, 4'h8, 2'b00, 32'h0};
      tbl[10] = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 2'b00, 32'hAAAD_BEEF};
      tbl[11] = '{1'b1, 32'h0000_3FFC, 32'h7777_7777, 4'hF, 2'b00, 32'h0};
      tbl[12] = '{1'b0, 32'h0000_3FFF, 32'h0,         4'h0, 2'b00, 32'h7777_7777};
      tbl[13] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 2'b10, 32'h0};
      tbl[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
      tbl[15] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 2'b00, 32'h7777_7777};

      // Reset state, then readies rise on the first edge after release.
      @(negedge clk);
      check("reset_ctrl", {awready, wready, bvalid, arready, rvalid}, 10'h0);
      check("reset_resp", {bresp[0], bresp[1], rresp[0], rresp[1]}, 8'h0);
      check("reset_rdata", rdata[0] | rdata[1], 32'h0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {awready, wready, arready}, 6'h3F);
      check("valid_after_reset", {bvalid, rvalid}, 4'h0);

      // Table-driven directed vectors (expectations for the base-0 instance).
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].is_wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
            check($sformatf("vec%0d_bresp", i), r, tbl[i].exp_resp);
         end else begin
            do_read(tbl[i].addr, d, r);
            check($sformatf("vec%0d_rresp", i), r, tbl[i].exp_resp);
            check($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
         end
      end

      // W three cycles ahead of AW with partial strobes; commit waits for AW.
      do_write(32'h10, 32'hDEAD_BEEF, 4'hF, r);
      wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
      check("w_first_ready", wready, 2'b11);
      @(negedge clk);
      wvalid = 1'b0;
      check("wready_drops", wready, 2'b00);
      check("no_commit_w_only", bvalid, 2'b00);
      repeat (2) @(negedge clk);
      check("still_no_commit", bvalid, 2'b00);
      check("awready_waiting", awready, 2'b11);
      awaddr = 32'h10; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      check("commit_on_aw", bvalid, 2'b11);
      model_write(32'h10, 32'h1122_3344, 4'b0101);
      wr_resp(32'h10, 0, r);
      do_read(32'h10, d, r);
      check("strobe_merge", d, 32'hDE22_BE44);

      // Non-zero base: just below the window errors, inside it works.
      rd_issue(32'h0FFC);
      check("base_below_rresp", rresp[1], 2'b10);
      rd_resp(32'h0FFC, 0, d, r);
      do_write(32'h1000, 32'h5A5A_5A5A, 4'hF, r);
      rd_issue(32'h1000);
      check("base_hit_rdata", rdata[1], 32'h5A5A_5A5A);
      rd_resp(32'h1000, 0, d, r);

      // Stalled B does not block reads; stalled R holds its data.
      wr_issue(32'h18, 32'h1357_9BDF, 4'hF);
      rd_issue(32'h10);
      rd_resp(32'h10, 4, d, r);
      check("read_during_bstall", d, 32'hDE22_BE44);
      check("bvalid_still_held", bvalid, 2'b11);
      check("wr_ready_still_low", {awready, wready}, 4'h0);
      wr_resp(32'h18, 2, r);

      // Read handshake on the same edge as a write commit returns old data.
      do_write(32'h20, 32'h0, 4'hF, r);
      awaddr = 32'h20; wdata = 32'hAAAA_5555; wstrb = 4'hF; araddr = 32'h20;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      check("collide_ready", {awready, wready, arready}, 6'h3F);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("collide_valids", {bvalid, rvalid}, 4'hF);
      check("collide_old_data", rdata[0], 32'h0);
      model_write(32'h20, 32'hAAAA_5555, 4'hF);
      rready = 1'b1;
      wr_resp(32'h20, 0, r);
      rready = 1'b0;
      do_read(32'h20, d, r);
      check("collide_new_data", d, 32'hAAAA_5555);

      // Reset with an AW held and R pending; the held AW must be discarded.
      awaddr = 32'h30; awvalid = 1'b1; araddr = 32'h10; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      check("pre_reset_state", {awready, wready, rvalid}, 6'b00_11_11);
      #2 reset = 1'b0;
      #1;
      check("async_reset_ctrl", {awready, wready, bvalid, arready, rvalid}, 10'h0);
      check("async_reset_data", rdata[0] | rdata[1] | 32'({bresp[0], bresp[1], rresp[0], rresp[1]}), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_mid_reset", {awready, wready, arready}, 6'h3F);
      wdata = 32'h0000_0099; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      repeat (3) @(negedge clk);
      check("no_stale_aw_commit", bvalid, 2'b00);
      awaddr = 32'h30; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      check("commit_after_reset", bvalid, 2'b11);
      model_write(32'h30, 32'h0000_0099, 4'hF);
      wr_resp(32'h30, 0, r);
      do_read(32'h30, d, r);
      check("post_reset_write", d, 32'h0000_0099);
      do_read(32'h10, d, r);
      check("ram_survives_reset", d, 32'hDE22_BE44);

      // Randomized traffic against the model: fill the pool, then mix ops.
      for (int k = 0; k < 16; k++) begin
         do_write(32'h0000 + 32'(k * 4), $urandom, 4'hF, r);
         do_write(32'h1000 + 32'(k * 4), $urandom, 4'hF, r);
      end
      do_write(32'h0FFC, $urandom, 4'hF, r);
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a = rand_addr();
         if ($urandom_range(0, 1) == 1) begin
            wr_issue(a, $urandom, 4'($urandom_range(0, 15)));
            wr_resp(a, $urandom_range(0, 2), r);
         end else begin
            rd_issue(a);
            rd_resp(a, $urandom_range(0, 2), d, r);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
